// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment receiver: segment patterns (active-low {a..g}),
// FSM state encoding and the default settle length.
package seg7_pkg;

    localparam int SEG7_STABLE_DEFAULT = 4;

    localparam logic [6:0] PAT_BLANK = 7'b1111111;

    localparam logic [6:0] PAT_D0 = 7'b0000001;
    localparam logic [6:0] PAT_D1 = 7'b1001111;
    localparam logic [6:0] PAT_D2 = 7'b0010010;
    localparam logic [6:0] PAT_D3 = 7'b0000110;
    localparam logic [6:0] PAT_D4 = 7'b1001100;
    localparam logic [6:0] PAT_D5 = 7'b0100100;
    localparam logic [6:0] PAT_D6 = 7'b0100000;
    localparam logic [6:0] PAT_D7 = 7'b0001111;
    localparam logic [6:0] PAT_D8 = 7'b0000000;
    localparam logic [6:0] PAT_D9 = 7'b0000100;

    localparam logic [6:0] PAT_HA = 7'b0001000;
    localparam logic [6:0] PAT_HB = 7'b1100000;
    localparam logic [6:0] PAT_HC = 7'b0110001;
    localparam logic [6:0] PAT_HD = 7'b1000010;
    localparam logic [6:0] PAT_HE = 7'b0110000;
    localparam logic [6:0] PAT_HF = 7'b0111000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Pattern -> digit code lookup; hex letters A..F decode only when SEG7_RX_HEX_EN is defined.
// Latency: combinational. Backpressure: none.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] code,
    output logic       err,
    output logic       blank
);

    always_comb begin
        code  = 4'hF;
        err   = 1'b1;
        blank = 1'b0;
        case (pattern)
            PAT_D0: begin code = 4'd0; err = 1'b0; end
            PAT_D1: begin code = 4'd1; err = 1'b0; end
            PAT_D2: begin code = 4'd2; err = 1'b0; end
            PAT_D3: begin code = 4'd3; err = 1'b0; end
            PAT_D4: begin code = 4'd4; err = 1'b0; end
            PAT_D5: begin code = 4'd5; err = 1'b0; end
            PAT_D6: begin code = 4'd6; err = 1'b0; end
            PAT_D7: begin code = 4'd7; err = 1'b0; end
            PAT_D8: begin code = 4'd8; err = 1'b0; end
            PAT_D9: begin code = 4'd9; err = 1'b0; end
`ifdef SEG7_RX_HEX_EN
            PAT_HA: begin code = 4'd10; err = 1'b0; end
            PAT_HB: begin code = 4'd11; err = 1'b0; end
            PAT_HC: begin code = 4'd12; err = 1'b0; end
            PAT_HD: begin code = 4'd13; err = 1'b0; end
            PAT_HE: begin code = 4'd14; err = 1'b0; end
            PAT_HF: begin code = 4'd15; err = 1'b0; end
`endif
            PAT_BLANK: begin err = 1'b0; blank = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/seg7_decoder_rx.sv
// Debounced 7-segment receiver: sync -> settle FSM -> one-entry result register (SEG7_RX_HEX_EN adds A..F).
// Latency: STABLE_CYCLES+3 edges from first sample to out_valid.
// Backpressure: single-entry output; a result issued while full and not drained is dropped and sets sticky overrun.
module seg7_decoder_rx
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = SEG7_STABLE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    input  logic       out_ready,
    input  logic       clr_overrun,
    output logic [3:0] out_bcd,
    output logic       out_err,
    output logic       out_valid,
    output logic       overrun
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);

    logic [6:0] sync1, sync2;
    logic [6:0] cand;
    logic [6:0] last_pat;
    logic       last_vld;
    logic [7:0] count;
    state_t     state;

    logic [3:0] dec_code;
    logic       dec_err;
    logic       dec_blank;
    logic       changed;
    logic       accept;
    logic       issue;
    logic       drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= PAT_BLANK;
            sync2 <= PAT_BLANK;
        end else begin
            sync1 <= seg_in;
            sync2 <= sync1;
        end
    end

    // Decoding the synchronized value covers both uses: blank detection when a
    // new candidate loads, and the code at acceptance (sync2 == cand then).
    seg7_pattern_decode u_decode (
        .pattern (sync2),
        .code    (dec_code),
        .err     (dec_err),
        .blank   (dec_blank)
    );

    assign changed = (sync2 != cand);
    assign accept  = (state == ST_SETTLE) && !changed && (count == CNT_MAX);
    assign issue   = accept && !(last_vld && (last_pat == cand));
    assign drop    = issue && out_valid && !out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cand     <= PAT_BLANK;
            count    <= 8'd0;
            last_pat <= PAT_BLANK;
            last_vld <= 1'b0;
        end else if (changed) begin
            cand <= sync2;
            if (dec_blank) begin
                state    <= ST_IDLE;
                count    <= 8'd0;
                last_vld <= 1'b0;
            end else begin
                state <= ST_SETTLE;
                count <= 8'd1;
            end
        end else begin
            case (state)
                ST_SETTLE: begin
                    if (count == CNT_MAX) begin
                        state <= ST_HOLD;
                        if (issue) begin
                            last_pat <= cand;
                            last_vld <= 1'b1;
                        end
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                ST_IDLE, ST_HOLD: ;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_bcd   <= 4'd0;
            out_err   <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (issue && (!out_valid || out_ready)) begin
                out_bcd   <= dec_code;
                out_err   <= dec_err;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
